// File: rtl/input_port_buffer.sv
// input_port_buffer - per-port flit FIFO that locks one route per packet and tags every flit with it
module input_port_buffer #(
  parameter int FLIT_WIDTH  = 16,
  parameter int HEADER_SIZE = 8,
  parameter int DEPTH       = 4,
  parameter int PTR_W       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [HEADER_SIZE-1:0] header,
  input  logic [HEADER_SIZE+1:0] modified_header,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  output logic [1:0]             out_route,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   proto_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [FLIT_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  state_t                 state;
  state_t                 state_nxt;
  logic [1:0]             route_q;
  logic [HEADER_SIZE-1:0] header_q;
  logic                   push;
  logic                   pop;
  logic                   empty;
  logic                   load_header;
  logic                   load_route;
  logic [FLIT_WIDTH-1:0]  front;
  logic [1:0]             front_type;
  logic                   unused_header_bits;

  assign front      = mem[rd_ptr];
  assign front_type = front[FLIT_WIDTH-1 -: 2];
  assign empty      = (count == '0);
  assign in_ready   = (count != FULL_COUNT);
  assign push       = in_valid & in_ready;
  assign header     = header_q;
  assign out_route  = route_q;

  // Only the route bits of the routing result are consumed here.
  assign unused_header_bits = ^modified_header[HEADER_SIZE-1:0];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      route_q  <= 2'b00;
      header_q <= '0;
    end else begin
      state <= state_nxt;
      // Header is latched while the head sits at the front, so it is stable for the whole ROUTE cycle.
      if (load_header) begin
        header_q <= front[HEADER_SIZE-1:0];
      end
      if (load_route) begin
        route_q <= modified_header[HEADER_SIZE+1:HEADER_SIZE];
      end
    end
  end

  // Type bit 0 marks a head (01/11), type bit 1 marks a tail (10/11).
  always_comb begin
    state_nxt   = state;
    pop         = 1'b0;
    proto_err   = 1'b0;
    out_valid   = 1'b0;
    out_flit    = '0;
    load_header = 1'b0;
    load_route  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (front_type[0]) begin
            load_header = 1'b1;
            state_nxt   = ROUTE;
          end else begin
            pop       = 1'b1;
            proto_err = 1'b1;
          end
        end
      end
      ROUTE: begin
        load_route = 1'b1;
        state_nxt  = ACTIVE;
      end
      ACTIVE: begin
        if (!empty) begin
          out_valid = 1'b1;
          out_flit  = front;
          if (out_ready) begin
            pop = 1'b1;
            if (front_type[1]) begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_input_port_buffer.sv
// tb/tb_input_port_buffer.sv - vector table, corner sequences and randomized scoreboard for input_port_buffer
module tb_input_port_buffer;
  localparam int FW = 16;
  localparam int HS = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] in_flit = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [HS-1:0] header;
  logic [HS+1:0] modified_header;
  logic [FW-1:0] out_flit;
  logic [1:0]    out_route;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          proto_err;
  logic          mh_force = 1'b0;
  logic [1:0]    mh_route = 2'b00;

  int n_pass = 0;
  int n_chk  = 0;

  typedef struct {
    logic [15:0] flit;
    logic [1:0]  route;
    logic [15:0] exp_flit;
    logic [1:0]  exp_route;
    logic        exp_err;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [1:0] route_fn(input logic [3:0] d);
    return d[1:0] ^ d[3:2];
  endfunction

  assign modified_header = {(mh_force ? mh_route : route_fn(header[3:0])), header};

  input_port_buffer #(.FLIT_WIDTH(FW), .HEADER_SIZE(HS), .DEPTH(D), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .header(header), .modified_header(modified_header), .out_flit(out_flit), .out_route(out_route),
    .out_valid(out_valid), .out_ready(out_ready), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          first_ov, ov_n, errs, err_cyc, k, full_at, n_out, mcount, drops, exp_drops, len;
  logic [15:0] got_f, pf;
  logic [1:0]  got_r;
  logic [7:0]  hdr;
  logic        stall;
  logic [15:0] pk[3];
  logic [1:0]  pr[3];
  logic [15:0] pg[3];
  int          pc[3];
  logic [15:0] l5[5];
  logic [15:0] got5[$];
  logic [15:0] src[$];
  logic [15:0] exp_f[$];
  logic [1:0]  exp_r[$];
  logic [3:0]  dest;
  logic [1:0]  ft;
  logic [15:0] fl;

  initial begin
    vecs[0] = '{16'hC0A5, 2'b01, 16'hC0A5, 2'b01, 1'b0};
    vecs[1] = '{16'h0007, 2'b00, 16'h0000, 2'b00, 1'b1};
    vecs[2] = '{16'hC0F3, 2'b11, 16'hC0F3, 2'b11, 1'b0};
    vecs[3] = '{16'h800C, 2'b10, 16'h0000, 2'b00, 1'b1};
    vecs[4] = '{16'hC012, 2'b10, 16'hC012, 2'b10, 1'b0};
    vecs[5] = '{16'hC3C0, 2'b00, 16'hC3C0, 2'b00, 1'b0};

    // Reset state, then an asynchronous reset in the middle of a packet.
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_proto_err", proto_err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("rst_header", header, 0);
    chk("rst_out_flit", out_flit, 0);
    chk("rst_out_route", out_route, 0);
    mh_force = 1'b1; mh_route = 2'b10;
    in_flit = 16'h4001; in_valid = 1'b1;
    @(negedge clk); in_flit = 16'h0002;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_out_flit", out_flit, 16'h4001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_in_ready", in_ready, 1);
    chk("async_out_valid", out_valid, 0);
    chk("async_proto_err", proto_err, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_out_valid", out_valid, 0);
    chk("post_rst_in_ready", in_ready, 1);

    // Single-flit vectors, including stray non-head flits that must be dropped.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mh_route = vecs[i].route;
      in_flit = vecs[i].flit; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      first_ov = 0; ov_n = 0; errs = 0; err_cyc = 0; got_f = '0; got_r = '0; hdr = '0;
      for (int c = 1; c <= 5; c++) begin
        if (proto_err) begin errs++; err_cyc = c; end
        if (out_valid) begin
          ov_n++;
          if (first_ov == 0) begin first_ov = c; got_f = out_flit; got_r = out_route; end
        end
        if (c == 2) hdr = header;
        @(negedge clk);
      end
      chk($sformatf("vec%0d_valid_cycles", i), ov_n, vecs[i].exp_err ? 0 : 1);
      chk($sformatf("vec%0d_proto_err", i), errs, vecs[i].exp_err ? 1 : 0);
      if (!vecs[i].exp_err) begin
        chk($sformatf("vec%0d_latency", i), first_ov, 3);
        chk($sformatf("vec%0d_flit", i), got_f, vecs[i].exp_flit);
        chk($sformatf("vec%0d_route", i), got_r, vecs[i].exp_route);
        chk($sformatf("vec%0d_header", i), hdr, vecs[i].flit[7:0]);
      end else begin
        chk($sformatf("vec%0d_err_cycle", i), err_cyc, 1);
      end
    end

    // Three-flit packet; routing output changes mid-packet but the locked route must not.
    pk[0] = 16'h4001; pk[1] = 16'h0002; pk[2] = 16'h8003;
    mh_route = 2'b10; k = 0; n_out = 0;
    for (int c = 0; c < 10; c++) begin
      if (k < 3) begin in_flit = pk[k]; in_valid = 1'b1; k++; end
      else in_valid = 1'b0;
      if (out_valid) begin
        if (n_out < 3) begin pg[n_out] = out_flit; pr[n_out] = out_route; pc[n_out] = c; end
        n_out++;
        mh_route = 2'b11;
      end
      @(negedge clk);
    end
    chk("pkt_count", n_out, 3);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("pkt_flit%0d", j), pg[j], pk[j]);
      chk($sformatf("pkt_route%0d", j), pr[j], 2'b10);
    end
    chk("pkt_consecutive", pc[2] - pc[0], 2);

    // Fill to DEPTH with the consumer stalled, then drain.
    l5[0] = 16'h4011; l5[1] = 16'h0012; l5[2] = 16'h0013; l5[3] = 16'h0014; l5[4] = 16'h8015;
    mh_route = 2'b01; out_ready = 1'b0; k = 0; full_at = -1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_flit = l5[(k < 5) ? k : 4];
      if (!in_ready && full_at < 0) full_at = k;
      if (in_ready) k++;
      @(negedge clk);
    end
    chk("full_after_pushes", full_at, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_out_valid", out_valid, 1);
    chk("full_out_flit", out_flit, 16'h4011);
    out_ready = 1'b1;
    got5.delete();
    for (int c = 0; c < 20; c++) begin
      in_valid = (k < 5); in_flit = l5[(k < 5) ? k : 4];
      if (c == 1) chk("in_ready_after_pop", in_ready, 1);
      if (in_valid && in_ready) k++;
      if (out_valid && out_ready) got5.push_back(out_flit);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("drain_count", got5.size(), 5);
    for (int j = 0; j < 5; j++) chk($sformatf("drain_flit%0d", j), (j < got5.size()) ? got5[j] : 16'hxxxx, l5[j]);

    // Randomized packets with stray flits, random handshakes and a reference scoreboard.
    do_reset();
    mh_force = 1'b0; exp_drops = 0;
    for (int p = 0; p < 40; p++) begin
      if ($urandom % 5 == 0) begin
        src.push_back({(($urandom % 2) != 0) ? 2'b10 : 2'b00, 14'($urandom)});
        exp_drops++;
      end
      len = $urandom_range(1, 5);
      dest = 4'($urandom);
      for (int j = 0; j < len; j++) begin
        if (len == 1) ft = 2'b11;
        else if (j == 0) ft = 2'b01;
        else if (j == len - 1) ft = 2'b10;
        else ft = ($urandom % 4 == 0) ? 2'b01 : 2'b00;
        fl = {ft, 14'($urandom)};
        if (j == 0) fl[3:0] = dest;
        src.push_back(fl);
        exp_f.push_back(fl);
        exp_r.push_back(route_fn(dest));
      end
    end
    mcount = 0; drops = 0; stall = 1'b0; pf = '0;
    for (int c = 0; c < 4000 && !(src.size() == 0 && exp_f.size() == 0); c++) begin
      chk("rnd_in_ready", in_ready, (mcount != D) ? 1 : 0);
      if (stall) begin
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_flit", out_flit, pf);
      end
      if (proto_err) begin
        drops++;
        chk("rnd_err_no_valid", out_valid, 0);
      end
      in_valid = (src.size() > 0) && ($urandom % 4 != 0);
      in_flit = in_valid ? src[0] : '0;
      out_ready = (c < 200) ? c[0] : 1'($urandom);
      if (in_valid && in_ready) begin void'(src.pop_front()); mcount++; end
      if (out_valid && out_ready) begin
        if (exp_f.size() == 0) chk("rnd_extra_flit", out_flit, 16'hxxxx);
        else begin
          chk("rnd_flit_route", {out_route, out_flit}, {exp_r.pop_front(), exp_f.pop_front()});
        end
        mcount--;
      end
      if (proto_err) mcount--;
      stall = out_valid && !out_ready;
      pf = out_flit;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_all_delivered", exp_f.size(), 0);
    chk("rnd_all_sent", src.size(), 0);
    chk("rnd_drops", drops, exp_drops);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
